// File: rtl/ex_mem_reg_if.sv
// ex_mem_reg_if: EX-side inputs and MEM-side outputs of the EX/MEM pipeline register.
interface ex_mem_reg_if #(
    parameter int DATA_WIDTH     = 64,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      ex_valid;
    logic [DATA_WIDTH-1:0]     ex_result;
    logic [DATA_WIDTH-1:0]     ex_store_data;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic                      ex_reg_write;
    logic                      ex_mem_read;
    logic                      ex_mem_write;
    logic                      ex_set_flags;
    logic [3:0]                ex_flags;
    logic                      stall;
    logic                      flush;
    logic                      mem_valid;
    logic [DATA_WIDTH-1:0]     mem_result;
    logic [DATA_WIDTH-1:0]     mem_store_data;
    logic [REG_ADDR_WIDTH-1:0] mem_rd;
    logic                      mem_reg_write;
    logic                      mem_mem_read;
    logic                      mem_mem_write;
    logic [3:0]                flags_q;
    logic [3:0]                flags_fwd;

    modport master (
        output ex_valid, ex_result, ex_store_data, ex_rd, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_set_flags, ex_flags, stall, flush,
        input  mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_write,
               mem_mem_read, mem_mem_write, flags_q, flags_fwd
    );

    modport slave (
        input  ex_valid, ex_result, ex_store_data, ex_rd, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_set_flags, ex_flags, stall, flush,
        output mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_write,
               mem_mem_read, mem_mem_write, flags_q, flags_fwd
    );
endinterface

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with architectural NZCV and same-cycle flag forwarding.
module ex_mem_reg #(
    parameter int DATA_WIDTH     = 64,
    parameter int REG_ADDR_WIDTH = 5
) (
    input logic         clk,
    input logic         rst_n,
    ex_mem_reg_if.slave bus
);
    logic                      valid_q;
    logic [DATA_WIDTH-1:0]     result_q;
    logic [DATA_WIDTH-1:0]     store_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic                      reg_write_q;
    logic                      mem_read_q;
    logic                      mem_write_q;
    logic [3:0]                nzcv_q;
    logic                      accept;
    logic                      flag_upd;
    logic                      xzr;

    assign accept   = bus.ex_valid & ~bus.stall & ~bus.flush;
    assign flag_upd = accept & bus.ex_set_flags;
    assign xzr      = &bus.ex_rd;

    // flush beats stall; data fields survive a flush, only the controls are killed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            store_q     <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (bus.flush) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (!bus.stall) begin
            valid_q     <= bus.ex_valid;
            result_q    <= bus.ex_result;
            store_q     <= bus.ex_store_data;
            rd_q        <= bus.ex_rd;
            reg_write_q <= bus.ex_valid & bus.ex_reg_write & ~xzr;
            mem_read_q  <= bus.ex_valid & bus.ex_mem_read;
            mem_write_q <= bus.ex_valid & bus.ex_mem_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            nzcv_q <= 4'b0000;
        else if (flag_upd)
            nzcv_q <= bus.ex_flags;
    end

    assign bus.mem_valid      = valid_q;
    assign bus.mem_result     = result_q;
    assign bus.mem_store_data = store_q;
    assign bus.mem_rd         = rd_q;
    assign bus.mem_reg_write  = reg_write_q;
    assign bus.mem_mem_read   = mem_read_q;
    assign bus.mem_mem_write  = mem_write_q;
    assign bus.flags_q        = nzcv_q;
    assign bus.flags_fwd      = !rst_n ? 4'b0000 : flag_upd ? bus.ex_flags : nzcv_q;
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: directed vectors for ex_mem_reg, checked against a spec-level model every cycle.
module tb_ex_mem_reg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ex_mem_reg_if #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5)) bus ();

    ex_mem_reg #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        valid;
        logic [63:0] result;
        logic [63:0] store;
        logic [4:0]  rd;
        logic        rw;
        logic        rd_en;
        logic        wr_en;
        logic [3:0]  flags;
    } mem_state_t;

    mem_state_t m;

    // Next MEM-stage contents from the pipeline-register rules
    function automatic mem_state_t next_state(mem_state_t cur);
        mem_state_t n = cur;
        if (bus.ex_valid && !bus.stall && !bus.flush && bus.ex_set_flags)
            n.flags = bus.ex_flags;
        if (bus.flush) begin
            n.valid = 0; n.rw = 0; n.rd_en = 0; n.wr_en = 0;
        end else if (!bus.stall) begin
            n.valid  = bus.ex_valid;
            n.result = bus.ex_result;
            n.store  = bus.ex_store_data;
            n.rd     = bus.ex_rd;
            n.rw     = bus.ex_valid && bus.ex_reg_write && bus.ex_rd != 5'd31;
            n.rd_en  = bus.ex_valid && bus.ex_mem_read;
            n.wr_en  = bus.ex_valid && bus.ex_mem_write;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            m <= '{valid: 0, result: 0, store: 0, rd: 0, rw: 0, rd_en: 0, wr_en: 0, flags: 0};
        else
            m <= next_state(m);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] fwd_exp();
        if (!rst_n) return 4'b0000;
        return (bus.ex_valid && !bus.stall && !bus.flush && bus.ex_set_flags) ? bus.ex_flags : m.flags;
    endfunction

    always @(negedge clk) begin
        chk("cmp_valid", {63'd0, bus.mem_valid}, {63'd0, m.valid});
        chk("cmp_result", bus.mem_result, m.result);
        chk("cmp_store", bus.mem_store_data, m.store);
        chk("cmp_rd", {59'd0, bus.mem_rd}, {59'd0, m.rd});
        chk("cmp_reg_write", {63'd0, bus.mem_reg_write}, {63'd0, m.rw});
        chk("cmp_mem_read", {63'd0, bus.mem_mem_read}, {63'd0, m.rd_en});
        chk("cmp_mem_write", {63'd0, bus.mem_mem_write}, {63'd0, m.wr_en});
        chk("cmp_flags_q", {60'd0, bus.flags_q}, {60'd0, m.flags});
        chk("cmp_flags_fwd", {60'd0, bus.flags_fwd}, {60'd0, fwd_exp()});
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        bus.ex_valid = 0; bus.ex_result = 0; bus.ex_store_data = 0; bus.ex_rd = 0;
        bus.ex_reg_write = 0; bus.ex_mem_read = 0; bus.ex_mem_write = 0;
        bus.ex_set_flags = 0; bus.ex_flags = 0; bus.stall = 0; bus.flush = 0;
        cyc(); cyc();
        chk("reset_valid", {63'd0, bus.mem_valid}, 64'd0);
        chk("reset_result", bus.mem_result, 64'd0);
        chk("reset_flags", {60'd0, bus.flags_q}, 64'd0);
        rst_n = 1;
        // basic capture
        bus.ex_valid = 1; bus.ex_result = 64'hF0; bus.ex_store_data = 64'h1234_5678_9ABC_DEF0;
        bus.ex_rd = 5; bus.ex_reg_write = 1;
        cyc();
        chk("basic_result", bus.mem_result, 64'hF0);
        chk("basic_store", bus.mem_store_data, 64'h1234_5678_9ABC_DEF0);
        chk("basic_rd", {59'd0, bus.mem_rd}, 64'd5);
        chk("basic_rw", {63'd0, bus.mem_reg_write}, 64'd1);
        chk("basic_valid", {63'd0, bus.mem_valid}, 64'd1);
        // asynchronous reset between edges
        rst_n = 0;
        #1;
        chk("async_valid", {63'd0, bus.mem_valid}, 64'd0);
        chk("async_result", bus.mem_result, 64'd0);
        chk("async_rw", {63'd0, bus.mem_reg_write}, 64'd0);
        chk("async_rd", {59'd0, bus.mem_rd}, 64'd0);
        cyc();
        rst_n = 1;
        // XZR destination
        bus.ex_rd = 31;
        cyc();
        chk("xzr_rw", {63'd0, bus.mem_reg_write}, 64'd0);
        chk("xzr_valid", {63'd0, bus.mem_valid}, 64'd1);
        chk("xzr_rd", {59'd0, bus.mem_rd}, 64'd31);
        // stall hold
        bus.ex_rd = 5; bus.ex_result = 64'hAA;
        cyc();
        chk("pre_stall_result", bus.mem_result, 64'hAA);
        bus.stall = 1; bus.ex_result = 64'hBB; bus.ex_set_flags = 1; bus.ex_flags = 4'b0100;
        #1;
        chk("stall_fwd", {60'd0, bus.flags_fwd}, 64'd0);
        repeat (3) cyc();
        chk("stall_result", bus.mem_result, 64'hAA);
        chk("stall_flags", {60'd0, bus.flags_q}, 64'd0);
        bus.stall = 0;
        #1;
        chk("unstall_fwd", {60'd0, bus.flags_fwd}, 64'd4);
        cyc();
        chk("unstall_result", bus.mem_result, 64'hBB);
        chk("unstall_flags", {60'd0, bus.flags_q}, 64'd4);
        // flush with stall
        bus.flush = 1; bus.stall = 1; bus.ex_mem_write = 1; bus.ex_reg_write = 0;
        bus.ex_result = 64'hCC; bus.ex_flags = 4'b1111;
        #1;
        chk("flush_fwd", {60'd0, bus.flags_fwd}, 64'd4);
        cyc();
        chk("flush_valid", {63'd0, bus.mem_valid}, 64'd0);
        chk("flush_wr", {63'd0, bus.mem_mem_write}, 64'd0);
        chk("flush_result", bus.mem_result, 64'hBB);
        chk("flush_flags", {60'd0, bus.flags_q}, 64'd4);
        bus.flush = 0; bus.stall = 0; bus.ex_mem_write = 0;
        // flag forwarding
        bus.ex_reg_write = 1; bus.ex_rd = 3; bus.ex_flags = 4'b0000;
        cyc();
        chk("fwd_clear", {60'd0, bus.flags_q}, 64'd0);
        bus.ex_flags = 4'b0110;
        #1;
        chk("fwd_same_cycle", {60'd0, bus.flags_fwd}, 64'd6);
        cyc();
        chk("fwd_flags_q", {60'd0, bus.flags_q}, 64'd6);
        bus.ex_set_flags = 0; bus.ex_flags = 4'b1001;
        #1;
        chk("fwd_no_set", {60'd0, bus.flags_fwd}, 64'd6);
        cyc();
        // bubble
        bus.ex_valid = 0; bus.ex_mem_read = 1;
        cyc();
        chk("bubble_valid", {63'd0, bus.mem_valid}, 64'd0);
        chk("bubble_rw", {63'd0, bus.mem_reg_write}, 64'd0);
        chk("bubble_rd_en", {63'd0, bus.mem_mem_read}, 64'd0);
        // reg_write and mem_write both passed through
        bus.ex_valid = 1; bus.ex_mem_read = 0; bus.ex_mem_write = 1; bus.ex_rd = 7;
        cyc();
        chk("both_rw", {63'd0, bus.mem_reg_write}, 64'd1);
        chk("both_wr", {63'd0, bus.mem_mem_write}, 64'd1);
        // plain flush keeps rd and data
        bus.flush = 1; bus.ex_rd = 9;
        cyc();
        chk("flush_rd_hold", {59'd0, bus.mem_rd}, 64'd7);
        bus.flush = 0;
        cyc(); cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX/MEM pipeline boundary of the LEGv8 pipeline. Sits directly downstream of the ALU (and/or/xor/add slices plus the result mux).
- Registers the ALU result, store data and control bits for the MEM stage.
- Owns the architectural NZCV flag register written by flag-setting ops (ADDS/SUBS/ANDS).
- Provides a forwarded flag view so B.cond in the same cycle sees freshly computed flags.

Parameters:
- DATA_WIDTH, 64, width of the result and store-data buses.
- REG_ADDR_WIDTH, 5, register-file index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ex_valid  input  1  EX holds a real instruction this cycle.
- ex_result  input  DATA_WIDTH  ALU result (address for LDUR/STUR).
- ex_store_data  input  DATA_WIDTH  Rt value for STUR.
- ex_rd  input  REG_ADDR_WIDTH  destination register.
- ex_reg_write  input  1  instruction writes the register file.
- ex_mem_read  input  1  load.
- ex_mem_write  input  1  store.
- ex_set_flags  input  1  instruction updates NZCV.
- ex_flags  input  4  ALU flags {N,Z,C,V}.
- stall  input  1  hold the register; MEM is not accepting.
- flush  input  1  kill the EX instruction; insert a bubble.
- mem_valid  output  1  MEM holds a real instruction.
- mem_result  output  DATA_WIDTH  registered result.
- mem_store_data  output  DATA_WIDTH  registered store data.
- mem_rd  output  REG_ADDR_WIDTH  registered destination.
- mem_reg_write  output  1  registered, qualified write enable.
- mem_mem_read  output  1  registered load control.
- mem_mem_write  output  1  registered store control.
- flags_q  output  4  architectural NZCV.
- flags_fwd  output  4  NZCV as seen by a same-cycle branch.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, including mem_valid, controls, data, mem_rd and flags_q. Takes effect immediately, independent of clk. Mid-operation reset discards the in-flight instruction and the flags.
- Latency: 1 cycle. Inputs sampled on a rising edge appear on the mem_* outputs after that edge.
- Define accept = ex_valid & ~stall & ~flush.
- Priority per edge: flush > stall > normal.
- flush=1:
  - mem_valid and mem_reg_write/mem_mem_read/mem_mem_write go to 0.
  - mem_result/mem_store_data/mem_rd hold their previous values.
  - flags_q unchanged.
  - flush overrides a simultaneous stall.
- stall=1, flush=0: every mem_* output and flags_q hold. EX must present the same instruction again next cycle.
- Normal (stall=0, flush=0):
  - mem_valid <= ex_valid.
  - Data and rd are captured.
  - Each control bit <= ex_valid & bit.
  - mem_reg_write is additionally forced to 0 when ex_rd == all-ones (XZR, register 31).
- ex_valid=0 with no stall/flush: bubble captured; controls 0, data don't-care (captured as is).
- mem_reg_write and mem_mem_write are mutually exclusive by the decoder. No checking in this block. If both are asserted, both are passed through.
- flags_q <= ex_flags on an edge where accept & ex_set_flags; otherwise it holds.
- flags_fwd is combinational and has no register delay:
  - equals ex_flags when accept & ex_set_flags;
  - otherwise equals flags_q.
  - During reset it equals 0.
- No storage beyond one entry. No back-pressure output: stall is driven by the hazard unit.

Test Plan:
- Reset/basic: hold rst_n=0, then release. Present ex_valid=1, ex_result=0x0000_0000_0000_00F0, ex_rd=5, ex_reg_write=1. Required: mem_result=0xF0, mem_rd=5, mem_reg_write=1, mem_valid=1 one edge later. Asserting rst_n=0 between edges clears all outputs immediately.
- XZR suppression: ex_rd=31, ex_reg_write=1, ex_valid=1. Required: mem_reg_write=0, mem_valid=1, mem_rd=31.
- Stall hold: capture result 0xAA. Then stall=1 for 3 cycles while inputs change to 0xBB with ex_set_flags=1, ex_flags=4'b0100. Required: mem_result stays 0xAA, flags_q unchanged, flags_fwd=flags_q. After stall drops: 0xBB captured and flags_q=4'b0100.
- Flush vs stall: flush=1 and stall=1 together with ex_mem_write=1. Required: mem_valid=0, mem_mem_write=0, mem_result holds its old value, flags_q unchanged.
- Flag forward: flags_q=4'b0000; ex_set_flags=1, ex_flags=4'b0110, ex_valid=1. Required: flags_fwd=4'b0110 in the same cycle and flags_q=4'b0110 after the edge. With ex_set_flags=0 and ex_flags=4'b1001: flags_fwd=4'b0110.
- Bubble: ex_valid=0, ex_reg_write=1, ex_mem_read=1. Required: mem_valid=0, mem_reg_write=0, mem_mem_read=0.
